inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: RESET_PC, 0, byte address fetched first after reset.
REQ-002 Parameter: ROM_BYTES, 100, instruction store size in bytes; last legal word address is ROM_BYTES-4.
REQ-003 Parameter: DEPTH, 4, instruction queue entries (power of two, >=2).
REQ-004 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port: rst  in  1  reset, asynchronous, active-high.
REQ-006 Port: rom_nrd  out  1  instruction store read enable, active-low.
REQ-007 Port: rom_addr  out  32  byte address of word being fetched.
REQ-008 Port: rom_data  in  32  fetched word, big-endian, valid same cycle as rom_nrd=0; high-Z otherwise.
REQ-009 Port: redirect  in  1  flush queue and restart fetch (branch/jump resolved).
REQ-010 Port: redirect_pc  in  32  new fetch address when redirect=1.
REQ-011 Port: deq_valid  out  1  queue head holds an instruction.
REQ-012 Port: deq_ready  in  1  issue stage accepts head this cycle.
REQ-013 Port: deq_inst  out  32  instruction word at queue head.
REQ-014 Port: deq_pc  out  32  byte address of instruction at queue head.
REQ-015 Port: fetch_done  out  1  fetch stopped at end of store.

Function
REQ-016 Block SHALL hold fetch PC register, DEPTH-entry FIFO of {pc, inst}, read/write pointers mod DEPTH, count 0..DEPTH, stopped flag.
REQ-017 Pop SHALL occur when deq_valid=1 and deq_ready=1; deq_valid SHALL equal (count!=0).
REQ-018 deq_inst/deq_pc SHALL be driven combinationally from the head entry; values when deq_valid=0 are don't-care.
REQ-019 Fetch SHALL be enabled when redirect=0, stopped=0, and (count<DEPTH or pop this cycle).
REQ-020 When fetch enabled: rom_nrd=0, rom_addr=PC; else rom_nrd=1 and rom_addr=PC (held).
REQ-021 On a fetch cycle the block SHALL push {PC, rom_data} at the clock edge and set PC=PC+4 (32-bit wrap); latency ROM-to-deq_valid = 1 cycle.
REQ-022 rom_data SHALL never be captured on a cycle with rom_nrd=1.
REQ-023 Simultaneous push and pop SHALL leave count unchanged; both pointers advance.
REQ-024 Full (count=DEPTH) with no pop SHALL stall: no fetch, PC unchanged, contents unchanged.
REQ-025 If PC > ROM_BYTES-4 at a would-be fetch cycle, block SHALL not fetch and SHALL set stopped=1 at that edge; fetch_done = stopped.
REQ-026 redirect=1 SHALL take priority: count=0, pointers=0, PC={redirect_pc[31:2],2'b00}, stopped=0, no push that cycle.
REQ-027 A pop handshaking in the redirect cycle SHALL count as consumed; queue is still emptied.
REQ-028 Misaligned redirect_pc SHALL be forced word-aligned (low 2 bits zero); no error signalled.

Reset
REQ-029 While rst=1 (asynchronously): PC=RESET_PC, count=0, pointers=0, stopped=0, deq_valid=0, fetch_done=0, rom_nrd=1.
REQ-030 Reset asserted mid-operation SHALL discard all queued entries; first fetch after deassertion is RESET_PC on the first rising edge with rst=0.

Verification
REQ-031 Reset, deq_ready=1 constant, ROM words 0x11111111,0x22222222 at 0,4 -> cycle1 deq_pc=0 deq_inst=0x11111111, cycle2 deq_pc=4 deq_inst=0x22222222.
REQ-032 deq_ready=0 for 10 cycles -> exactly 4 pushes (addresses 0,4,8,12), then rom_nrd=1 and rom_addr=16 held; raising deq_ready pops 0 and fetches 16 same cycle.
REQ-033 Queue holding 3 entries, redirect=1 with redirect_pc=0x22 -> next cycle deq_valid=0, rom_addr=0x20, following cycle deq_pc=0x20.
REQ-034 ROM_BYTES=100, free-running -> last fetch at 96, fetch_done=1 afterwards, rom_nrd stays 1; redirect to 0 clears fetch_done and resumes.
REQ-035 rst pulsed while queue full and fetching -> deq_valid=0 immediately (no clock), after release deq_pc sequence restarts at RESET_PC.
REQ-036 Checker: every pushed entry satisfies inst==ROM word at pc; no captures while rom_nrd=1; count never exceeds DEPTH.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Fetch-unit bus: instruction-store read port, redirect input and
// issue-side dequeue handshake. master = fetch unit, slave = environment.
interface inst_fetch_if;
    logic        rom_nrd;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_inst;
    logic [31:0] deq_pc;
    logic        fetch_done;

    modport master (
        output rom_nrd, rom_addr, deq_valid, deq_inst, deq_pc, fetch_done,
        input  rom_data, redirect, redirect_pc, deq_ready
    );

    modport slave (
        input  rom_nrd, rom_addr, deq_valid, deq_inst, deq_pc, fetch_done,
        output rom_data, redirect, redirect_pc, deq_ready
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: sequential word fetch from a fixed-size store
// into a small {pc, inst} queue, with redirect flush and end-of-store stop.
module inst_fetch #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int          ROM_BYTES = 100,
    parameter int          DEPTH     = 4
) (
    input logic         clk,
    input logic         rst,
    inst_fetch_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [31:0]   LAST_PC = 32'(ROM_BYTES - 4);

    logic [31:0]   pc_q, pc_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stop_q, stop_d;

    logic [31:0]   mem_pc   [DEPTH];
    logic [31:0]   mem_inst [DEPTH];

    logic pop, slot, in_range, fetch;

    // A fetch needs a free slot (or one freed by this cycle's pop); the rst
    // term keeps the store read disabled while reset is held.
    assign pop      = (cnt_q != '0) && bus.deq_ready;
    assign slot     = !rst && !bus.redirect && !stop_q && ((cnt_q < DEPTH_C) || pop);
    assign in_range = (pc_q <= LAST_PC);
    assign fetch    = slot && in_range;

    assign bus.rom_nrd    = !fetch;
    assign bus.rom_addr   = pc_q;
    assign bus.deq_valid  = (cnt_q != '0);
    assign bus.deq_inst   = mem_inst[rptr_q];
    assign bus.deq_pc     = mem_pc[rptr_q];
    assign bus.fetch_done = stop_q;

    // Next-state: redirect flushes everything; otherwise push/pop/stop.
    always_comb begin
        pc_d   = pc_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        stop_d = stop_q;
        if (bus.redirect) begin
            pc_d   = {bus.redirect_pc[31:2], 2'b00};
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
            stop_d = 1'b0;
        end else begin
            if (pop)
                rptr_d = rptr_q + 1'b1;
            if (fetch) begin
                wptr_d = wptr_q + 1'b1;
                pc_d   = pc_q + 32'd4;
            end else if (slot) begin
                // would-be fetch past the last word: park here for good
                stop_d = 1'b1;
            end
            case ({fetch, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            stop_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            stop_q <= stop_d;
        end
    end

    // Queue storage: captured only on real fetch cycles, never reset.
    always_ff @(posedge clk) begin
        if (fetch) begin
            mem_pc[wptr_q]   <= pc_q;
            mem_inst[wptr_q] <= bus.rom_data;
        end
    end
endmodule
